replay_fsm_param: RTL and testbench
===================================

Name: replay_fsm_param

Overview:
- Parametrised next-generation controller for the data-link-layer replay buffer FIFO.
- Sequences TLP segment writes into the buffer, forwards ACKs to advance the read pointer, and runs NAK/timeout replays with physical-layer busy_n handshaking.
- New over the previous controller:
  - one segment per cycle on writes and replays;
  - queuing of ACK/NAK/TO events that arrive while busy;
  - a REPLAY_NUM counter that requests link retrain after REPLAY_MAX consecutive replays.
- Sits between the TLP segment mux/FIFO and the physical-layer interface.

Parameters:
- SEGS_PER_TLP, 10: segments written per TLP. Must be ≥2.
- CNT_W, 12: width of num_to_rep and rep_idx.
- REPLAY_MAX, 3: replays allowed before a retrain request. Must be 1..255.
- Local: SEL_W = clog2(SEGS_PER_TLP).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- we_i  in  1  write request for one TLP
- acknak_i  in  2  01=ACK, 10=NAK, others=none
- to_i  in  1  replay timer timeout
- busy_n  in  1  physical layer ready (1 = not busy)
- rdy_i  in  1  FIFO has space
- num_to_rep  in  CNT_W  entries to replay, from FIFO
- rst  out  1  FIFO reset pulse
- we_o  out  1  FIFO write enable
- seg_sel  out  SEL_W  segment mux select
- acknak_o  out  2  forwarded ACK/NAK
- to_o  out  1  forwarded timeout
- rep  out  1  replay-read strobe
- rep_idx  out  CNT_W  replay index to FIFO
- rdy_o  out  1  ready to accept a TLP
- busy_n_o  out  1  controller not in replay handshake
- retrain_o  out  1  one-cycle link-retrain request
- replay_num_o  out  8  current replay count

Behaviour:
- Reset and output timing:
  - All state changes on the rising edge of clk. reset_n is sampled synchronously.
  - While reset_n=0 the FSM is forced to RESET, and pending flags, replay_num, counters and captured registers are cleared. This also applies mid-write or mid-replay, which is aborted with no further we_o/rep.
  - Outputs are Moore-decoded from state and registers; there is no combinational input-to-output path.
  - Reset values: rst=1, busy_n_o=1, all other outputs 0.
- RESET: rst=1 for exactly one cycle after reset_n releases, then IDLE.
- IDLE:
  - rdy_o=rdy_i registered one cycle; busy_n_o=1; counter cleared.
  - Priority order:
    1. we_i → WRITE
    2. ACK (live or pending) → ACK
    3. NAK/TO (live or pending) → REPLAY_REQ, or RETRAIN if replay_num==REPLAY_MAX
  - A pending flag is cleared when it is serviced.
- Pending events:
  - In any state other than IDLE or RESET, acknak_i==01 sets pend_ack.
  - acknak_i==10 or to_i sets pend_rep and latches kind {nak,to}; the last event wins.
  - we_i outside IDLE is ignored.
- WRITE:
  - SEGS_PER_TLP consecutive cycles with we_o=1 and seg_sel=0,1,…,SEGS_PER_TLP-1.
  - Returns to IDLE after the last segment. First we_o is the cycle after we_i is sampled.
- ACK: one cycle with acknak_o=01; replay_num cleared to 0; then IDLE.
- REPLAY_REQ:
  - One cycle with acknak_o/to_o driven from the latched kind (NAK: 10/0, TO: 00/1).
  - busy_n_o=0; replay_num increments (saturating); then WAIT_PHY.
- WAIT_PHY:
  - Holds acknak_o/to_o and busy_n_o=0.
  - Captures num_to_rep into count_to every cycle.
  - Exits when busy_n=1: to REPLAY if count_to≠0, else IDLE.
- REPLAY:
  - busy_n_o=0. While busy_n=1: rep=1 with rep_idx=k, and k advances by 1 per cycle from 0.
  - While busy_n=0: rep=0 and k holds.
  - After the strobe with k=count_to-1 is issued → IDLE. Exactly count_to strobes are issued; k never wraps.
- RETRAIN: one cycle with retrain_o=1; replay_num cleared; pend_rep cleared; then IDLE. No replay is issued.
- Simultaneous events:
  - ACK and NAK are never simultaneous (encoded in one field).
  - NAK and to_i together are treated as NAK.
  - we_i together with ACK in IDLE: WRITE first, ACK serviced afterwards via pend_ack.

Test Plan:
- Release reset → rst=1 for exactly 1 cycle. Then IDLE with busy_n_o=1, and rdy_o follows rdy_i one cycle late.
- Pulse we_i in IDLE → we_o high for 10 consecutive cycles with seg_sel 0..9. Return to IDLE. No extra we_o.
- acknak_i=10, num_to_rep=5, busy_n low 3 cycles then high, with busy_n dropped for 2 cycles after the 2nd strobe → acknak_o=10 throughout REPLAY_REQ/WAIT_PHY. Exactly 5 rep strobes with rep_idx 0,1,2,3,4; rep=0 during the gap.
- Four NAKs with no intervening ACK, REPLAY_MAX=3 → replay_num_o goes 1,2,3. The 4th NAK yields retrain_o for 1 cycle, no rep, and replay_num_o=0. Also: NAK, NAK, ACK, NAK → replay_num_o=1.
- we_i and acknak_i=01 in the same IDLE cycle → 10 writes, then one ACK cycle with acknak_o=01. A to_i during WRITE → replay with to_o=1 after the write completes.
- Assert reset_n=0 mid-REPLAY (rep_idx=2 of 6) → rep=0 the next cycle, outputs at reset values. After release, pending flags are clear and replay_num_o=0.

Source files
------------

// File: rtl/replay_fsm_param_if.sv
// Replay-buffer controller bus.
// Groups the controller's handshake and FIFO-facing signals.
//   slave  : the controller's view. Link-layer requests and PHY/FIFO status
//            come in; FIFO strobes and forwarded events go out.
//   master : the environment's view (segment mux, FIFO, physical layer).
// Signal names keep the _i/_o suffixes as seen from the controller.
interface replay_fsm_param_if #(
  parameter int SEGS_PER_TLP = 10,
  parameter int CNT_W        = 12
);
  localparam int SEL_W = $clog2(SEGS_PER_TLP);

  logic             we_i;
  logic [1:0]       acknak_i;
  logic             to_i;
  logic             busy_n;
  logic             rdy_i;
  logic [CNT_W-1:0] num_to_rep;

  logic             rst;
  logic             we_o;
  logic [SEL_W-1:0] seg_sel;
  logic [1:0]       acknak_o;
  logic             to_o;
  logic             rep;
  logic [CNT_W-1:0] rep_idx;
  logic             rdy_o;
  logic             busy_n_o;
  logic             retrain_o;
  logic [7:0]       replay_num_o;

  modport slave (
    input  we_i, acknak_i, to_i, busy_n, rdy_i, num_to_rep,
    output rst, we_o, seg_sel, acknak_o, to_o, rep, rep_idx,
           rdy_o, busy_n_o, retrain_o, replay_num_o
  );

  modport master (
    output we_i, acknak_i, to_i, busy_n, rdy_i, num_to_rep,
    input  rst, we_o, seg_sel, acknak_o, to_o, rep, rep_idx,
           rdy_o, busy_n_o, retrain_o, replay_num_o
  );
endinterface

// File: rtl/replay_fsm_param.sv
// Replay-buffer controller for the data-link layer.
// Writes TLP segments into the replay FIFO, forwards ACKs, and runs NAK /
// timeout replays with busy_n handshaking towards the physical layer. Events
// that arrive while the controller is busy are queued in pending flags and
// serviced from IDLE. After REPLAY_MAX consecutive replays the next replay
// request turns into a one-cycle link-retrain request instead.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : we_i/acknak_i/to_i requests, busy_n/rdy_i/num_to_rep status;
//                  rst/we_o/seg_sel/rep/rep_idx FIFO controls, acknak_o/to_o
//                  forwarded events, rdy_o/busy_n_o/retrain_o/replay_num_o status.
// All outputs are decoded from registers only.
module replay_fsm_param #(
  parameter int SEGS_PER_TLP = 10,
  parameter int CNT_W        = 12,
  parameter int REPLAY_MAX   = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  replay_fsm_param_if.slave   bus
);
  localparam int               SEL_W    = $clog2(SEGS_PER_TLP);
  localparam logic [SEL_W-1:0] SEG_LAST = SEL_W'(SEGS_PER_TLP - 1);
  localparam logic [7:0]       RMAX     = 8'(REPLAY_MAX);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_WRITE, S_ACK, S_REPLAY_REQ, S_WAIT_PHY, S_REPLAY, S_RETRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] seg_q, seg_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] count_to_q, count_to_d;
  logic [CNT_W-1:0] rep_idx_q, rep_idx_d;
  logic             rep_q, rep_d;
  logic             pend_ack_q, pend_ack_d;
  logic             pend_rep_q, pend_rep_d;
  logic             kind_nak_q, kind_nak_d;  // kind of the queued replay event
  logic             cur_nak_q, cur_nak_d;    // kind of the replay being forwarded
  logic             rdy_q;
  logic [7:0]       rnum_q, rnum_d;

  logic live_ack, live_nak, live_rep;
  logic eff_ack, eff_rep, eff_nak;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A NAK together with a timeout counts as a NAK.
  assign live_ack = (bus.acknak_i == 2'b01);
  assign live_nak = (bus.acknak_i == 2'b10);
  assign live_rep = live_nak | bus.to_i;
  assign eff_ack  = pend_ack_q | live_ack;
  assign eff_rep  = pend_rep_q | live_rep;
  assign eff_nak  = live_rep ? live_nak : kind_nak_q;

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    k_d        = k_q;
    count_to_d = count_to_q;
    rep_idx_d  = rep_idx_q;
    rep_d      = 1'b0;
    pend_ack_d = pend_ack_q;
    pend_rep_d = pend_rep_q;
    kind_nak_d = kind_nak_q;
    cur_nak_d  = cur_nak_q;
    rnum_d     = rnum_q;

    // Outside IDLE, incoming events are only queued; the last replay kind wins.
    if (state_q != S_IDLE && state_q != S_RESET) begin
      pend_ack_d = pend_ack_q | live_ack;
      if (live_rep) begin
        pend_rep_d = 1'b1;
        kind_nak_d = live_nak;
      end
    end

    unique case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        seg_d = '0;
        k_d   = '0;
        // Live events not serviced this cycle are folded into the pending flags.
        if (bus.we_i) begin
          state_d    = S_WRITE;
          pend_ack_d = eff_ack;
          pend_rep_d = eff_rep;
          kind_nak_d = eff_nak;
        end else if (eff_ack) begin
          state_d    = S_ACK;
          pend_ack_d = 1'b0;
          pend_rep_d = eff_rep;
          kind_nak_d = eff_nak;
        end else if (eff_rep) begin
          pend_rep_d = 1'b0;
          kind_nak_d = eff_nak;
          cur_nak_d  = eff_nak;
          state_d    = (rnum_q == RMAX) ? S_RETRAIN : S_REPLAY_REQ;
        end
      end
      S_WRITE: begin
        seg_d = seg_q + SEL_W'(1);
        if (seg_q == SEG_LAST) begin
          seg_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        rnum_d  = 8'd0;
        state_d = S_IDLE;
      end
      S_REPLAY_REQ: begin
        rnum_d  = sat_inc8(rnum_q);
        state_d = S_WAIT_PHY;
      end
      S_WAIT_PHY: begin
        // The exit decision uses the value being captured on the same edge.
        count_to_d = bus.num_to_rep;
        k_d        = '0;
        if (bus.busy_n) state_d = (bus.num_to_rep != '0) ? S_REPLAY : S_IDLE;
      end
      S_REPLAY: begin
        if (bus.busy_n) begin
          rep_d     = 1'b1;
          rep_idx_d = k_q;
          k_d       = k_q + ONE;
          if (k_q == count_to_q - ONE) state_d = S_IDLE;
        end
      end
      S_RETRAIN: begin
        rnum_d     = 8'd0;
        pend_rep_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_RESET;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_RESET;
      seg_q      <= '0;
      k_q        <= '0;
      count_to_q <= '0;
      rep_idx_q  <= '0;
      rep_q      <= 1'b0;
      pend_ack_q <= 1'b0;
      pend_rep_q <= 1'b0;
      kind_nak_q <= 1'b0;
      cur_nak_q  <= 1'b0;
      rdy_q      <= 1'b0;
      rnum_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      k_q        <= k_d;
      count_to_q <= count_to_d;
      rep_idx_q  <= rep_idx_d;
      rep_q      <= rep_d;
      pend_ack_q <= pend_ack_d;
      pend_rep_q <= pend_rep_d;
      kind_nak_q <= kind_nak_d;
      cur_nak_q  <= cur_nak_d;
      rdy_q      <= bus.rdy_i;
      rnum_q     <= rnum_d;
    end
  end

  // Moore output decode
  logic fwd_rep;
  assign fwd_rep          = (state_q == S_REPLAY_REQ) || (state_q == S_WAIT_PHY);
  assign bus.rst          = (state_q == S_RESET);
  assign bus.we_o         = (state_q == S_WRITE);
  assign bus.seg_sel      = (state_q == S_WRITE) ? seg_q : '0;
  assign bus.acknak_o     = (state_q == S_ACK) ? 2'b01 :
                            (fwd_rep && cur_nak_q) ? 2'b10 : 2'b00;
  assign bus.to_o         = fwd_rep && !cur_nak_q;
  assign bus.rep          = rep_q;
  assign bus.rep_idx      = rep_idx_q;
  assign bus.rdy_o        = (state_q == S_IDLE) && rdy_q;
  assign bus.busy_n_o     = !(fwd_rep || (state_q == S_REPLAY));
  assign bus.retrain_o    = (state_q == S_RETRAIN);
  assign bus.replay_num_o = rnum_q;
endmodule

// File: tb/tb_replay_fsm_param.sv
module tb_replay_fsm_param;
  localparam int SEGS = 10;
  localparam int CW   = 12;
  localparam int RMAX = 3;

  localparam int EV_WR  = 0;
  localparam int EV_REP = 1;
  localparam int EV_ACK = 2;
  localparam int EV_NAK = 3;
  localparam int EV_TO  = 4;
  localparam int EV_RT  = 5;
  localparam int EV_BAD = 6;

  typedef struct { int typ; int val; } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  bit   phy_rand;
  bit   phy_force;
  int   n_tests;
  int   n_fail;
  int   model_rnum;
  ev_t  exp_q[$];

  always #5 clk = ~clk;

  replay_fsm_param_if #(.SEGS_PER_TLP(SEGS), .CNT_W(CW)) bus();

  replay_fsm_param #(.SEGS_PER_TLP(SEGS), .CNT_W(CW), .REPLAY_MAX(RMAX)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe(input int typ, input int val);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected event: got type %0d val %0d, expected none", typ, val);
    end else begin
      e = exp_q.pop_front();
      if (e.typ != typ || e.val != val) begin
        n_fail++;
        $display("FAIL scoreboard: got type %0d val %0d, expected type %0d val %0d",
                 typ, val, e.typ, e.val);
      end
    end
  endtask

  task automatic push(input int typ, input int val);
    ev_t e;
    e.typ = typ;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Reference model: what the controller must emit for each serviced event.
  task automatic model_write();
    for (int i = 0; i < SEGS; i++) push(EV_WR, i);
  endtask

  task automatic model_ack();
    push(EV_ACK, model_rnum);
    model_rnum = 0;
  endtask

  task automatic model_replay(input bit is_nak, input int n);
    if (model_rnum == RMAX) begin
      push(EV_RT, model_rnum);
      model_rnum = 0;
    end else begin
      push(is_nak ? EV_NAK : EV_TO, model_rnum);
      model_rnum = (model_rnum < 255) ? model_rnum + 1 : 255;
      for (int i = 0; i < n; i++) push(EV_REP, i);
    end
  endtask

  // Physical layer: either randomly busy or following phy_force.
  initial begin
    bus.busy_n = 1'b1;
    forever begin
      @(negedge clk);
      bus.busy_n = phy_rand ? ($urandom_range(0, 3) != 0) : phy_force;
    end
  end

  // Monitor: every output transaction is popped against the scoreboard.
  initial begin
    logic [2:0] prev_ak, cur_ak;
    prev_ak = 3'b000;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.we_o) observe(EV_WR, int'(bus.seg_sel));
        if (bus.rep) observe(EV_REP, int'(bus.rep_idx));
        if (bus.retrain_o) observe(EV_RT, int'(bus.replay_num_o));
        cur_ak = {bus.acknak_o, bus.to_o};
        if (cur_ak != 3'b000 && cur_ak != prev_ak) begin
          case (cur_ak)
            3'b010:  observe(EV_ACK, int'(bus.replay_num_o));
            3'b100:  observe(EV_NAK, int'(bus.replay_num_o));
            3'b001:  observe(EV_TO, int'(bus.replay_num_o));
            default: observe(EV_BAD, int'(cur_ak));
          endcase
        end
        prev_ak = cur_ak;
      end else begin
        prev_ak = 3'b000;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, " ctrl outs"},
          int'({bus.rst, bus.busy_n_o, bus.we_o, bus.rep, bus.rdy_o,
                bus.retrain_o, bus.to_o, bus.acknak_o}), 'b110000000);
    check({tag, " replay_num_o"}, int'(bus.replay_num_o), 0);
    check({tag, " seg_sel"}, int'(bus.seg_sel), 0);
    check({tag, " rep_idx"}, int'(bus.rep_idx), 0);
  endtask

  // Waits for a stable IDLE, then checks the replay count against the model.
  task automatic wait_idle(input string tag);
    int run = 0;
    int cyc = 0;
    while (run < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      run = (bus.rdy_o && bus.busy_n_o) ? run + 1 : 0;
    end
    check({tag, " reached idle"}, int'(run >= 4), 1);
    check({tag, " replay_num_o"}, int'(bus.replay_num_o), model_rnum);
  endtask

  task automatic drive_rep(input int r);
    if (r == 1 || r == 3) bus.acknak_i = 2'b10;
    if (r == 2 || r == 3) bus.to_i = 1'b1;
  endtask

  // r: 0 ACK, 1 NAK, 2 TO, 3 NAK+TO together
  task automatic op_event(input int r, input int n);
    bus.num_to_rep = CW'(n);
    @(negedge clk);
    if (r == 0) begin
      bus.acknak_i = 2'b01;
      model_ack();
    end else begin
      drive_rep(r);
      model_replay(r != 2, n);
    end
    @(negedge clk);
    bus.acknak_i = 2'b00;
    bus.to_i = 1'b0;
    wait_idle("event");
  endtask

  // Write a TLP, optionally with an ACK in the same cycle and events during it.
  task automatic op_write(input bit same_ack, input bit inj_ack, input int rep1,
                          input int rep2, input int n);
    int last;
    bus.num_to_rep = CW'(n);
    @(negedge clk);
    bus.we_i = 1'b1;
    if (same_ack) bus.acknak_i = 2'b01;
    model_write();
    @(negedge clk);
    bus.we_i = 1'b0;
    bus.acknak_i = 2'b00;
    for (int c = 1; c < 8; c++) begin
      if (c == 2 && inj_ack) bus.acknak_i = 2'b01;
      if (c == 4) drive_rep(rep1);
      if (c == 6) drive_rep(rep2);
      @(negedge clk);
      bus.acknak_i = 2'b00;
      bus.to_i = 1'b0;
    end
    if (same_ack || inj_ack) model_ack();
    last = (rep2 != 0) ? rep2 : rep1;
    if (last != 0) model_replay(last != 2, n);
    wait_idle("write");
  endtask

  task automatic op_nak_script();
    int seen = 0;
    int cyc = 0;
    phy_rand = 1'b0;
    phy_force = 1'b0;
    bus.num_to_rep = CW'(5);
    @(negedge clk);
    bus.acknak_i = 2'b10;
    model_replay(1'b1, 5);
    @(negedge clk);
    bus.acknak_i = 2'b00;
    repeat (3) @(negedge clk);
    phy_force = 1'b1;
    while (seen < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.rep) seen++;
    end
    check("scripted nak two strobes", seen, 2);
    phy_force = 1'b0;
    repeat (2) @(negedge clk);
    phy_force = 1'b1;
    wait_idle("nak script");
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check({tag, " rst first cycle"}, int'(bus.rst), 1);
    @(negedge clk);
    check({tag, " rst second cycle"}, int'(bus.rst), 0);
    check({tag, " busy_n_o idle"}, int'(bus.busy_n_o), 1);
  endtask

  task automatic op_reset_mid();
    int  cyc = 0;
    bit  hit = 1'b0;
    phy_rand = 1'b0;
    phy_force = 1'b1;
    op_event(0, 0);
    bus.num_to_rep = CW'(6);
    @(negedge clk);
    bus.acknak_i = 2'b10;
    model_replay(1'b1, 6);
    while (!hit && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.acknak_i = 2'b00;
      if (bus.rep && bus.rep_idx == CW'(0)) bus.acknak_i = 2'b01;
      if (bus.rep && bus.rep_idx == CW'(2)) hit = 1'b1;
    end
    check("mid replay reached idx2", int'(hit), 1);
    reset_n = 1'b0;
    bus.acknak_i = 2'b00;
    @(negedge clk);
    check("mid reset rep dropped", int'(bus.rep), 0);
    check_reset_outs("mid reset");
    @(negedge clk);
    check("mid reset strobes left unissued", exp_q.size(), 3);
    exp_q.delete();
    model_rnum = 0;
    release_reset("mid reset");
    wait_idle("after mid reset");
    op_event(1, 2);
  endtask

  initial begin
    int op;
    n_tests = 0;
    n_fail = 0;
    model_rnum = 0;
    phy_rand = 1'b0;
    phy_force = 1'b1;
    reset_n = 1'b0;
    bus.we_i = 1'b0;
    bus.acknak_i = 2'b00;
    bus.to_i = 1'b0;
    bus.rdy_i = 1'b0;
    bus.num_to_rep = '0;

    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    release_reset("initial");
    check("rdy_o low while rdy_i low", int'(bus.rdy_o), 0);
    bus.rdy_i = 1'b1;
    @(negedge clk);
    check("rdy_o follows rdy_i high", int'(bus.rdy_o), 1);
    bus.rdy_i = 1'b0;
    @(negedge clk);
    check("rdy_o follows rdy_i low", int'(bus.rdy_o), 0);
    bus.rdy_i = 1'b1;
    @(negedge clk);

    op_write(1'b0, 1'b0, 0, 0, 0);
    op_nak_script();

    op_event(0, 0);
    for (int i = 0; i < 4; i++) op_event(1, int'($urandom_range(0, 4)));
    op_event(1, 1);
    op_event(1, 2);
    op_event(0, 0);
    op_event(1, 3);

    op_write(1'b1, 1'b0, 0, 0, 0);
    op_write(1'b0, 1'b0, 2, 0, 3);
    op_event(3, 2);

    phy_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0: op_write(1'b0, 1'b0, 0, 0, 0);
        1: op_write(1'b1, 1'b0, 0, 0, 0);
        2: op_write(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        3: op_event(0, 0);
        default: op_event(op - 3, int'($urandom_range(0, 6)));
      endcase
    end

    op_reset_mid();

    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
